// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared UART definitions: data width and receiver state encoding.
// Revision: 1.0  initial release
// ============================================================================
package uart_pkg;

    localparam int c_DATA_BITS = 8;
    localparam int c_BIT_IDX_W = $clog2(c_DATA_BITS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_rx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
// Module  : uart_bit_timer
// Brief   : Bit-period cycle counter; done marks the last cycle of a full or
//           half bit period, after which the count restarts from zero.
// Revision: 1.0  initial release
// ============================================================================
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic half,
    output logic done
);

    localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_FULL_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] w_last;

    assign w_last = half ? c_HALF_LAST : c_FULL_LAST;
    assign done   = !clear && (r_count == w_last);

    // Wrapping on done keeps the count bounded by the full-period terminal value.
    always_ff @(posedge clk) begin
        if (rst || clear || done) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_ctrl
// Brief   : 8N1 UART receiver with valid/ready output, frame-error and
//           overrun pulses, and break detection on a held-low line.
// Revision: 1.0  initial release
// ============================================================================
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_rx,
    output logic [c_DATA_BITS-1:0] o_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic                   o_frame_err,
    output logic                   o_overrun,
    output logic                   o_busy
);

    localparam logic [c_BIT_IDX_W-1:0] c_LAST_BIT = c_BIT_IDX_W'(c_DATA_BITS - 1);

    uart_rx_state_e         r_state;
    uart_rx_state_e         w_state_next;
    logic [c_BIT_IDX_W-1:0] r_bit_idx;
    logic [c_DATA_BITS-1:0] r_shift;
    logic                   w_tmr_clear;
    logic                   w_tmr_half;
    logic                   w_tmr_done;
    logic                   w_deliver;
    logic                   w_stop_err;

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk   (i_clk),
        .rst   (i_rst),
        .clear (w_tmr_clear),
        .half  (w_tmr_half),
        .done  (w_tmr_done)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_tmr_clear  = 1'b0;
        w_tmr_half   = 1'b0;
        w_deliver    = 1'b0;
        w_stop_err   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_tmr_clear = 1'b1;
                if (!i_rx) begin
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                w_tmr_half = 1'b1;
                if (w_tmr_done) begin
                    w_state_next = i_rx ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_tmr_done && (r_bit_idx == c_LAST_BIT)) begin
                    w_state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_tmr_done) begin
                    if (i_rx) begin
                        w_deliver    = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_stop_err   = 1'b1;
                        w_state_next = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                w_tmr_clear = 1'b1;
                if (i_rx) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_tmr_clear  = 1'b1;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bit_idx   <= '0;
            r_shift     <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            o_frame_err <= w_stop_err;
            o_overrun   <= w_deliver && o_valid && !i_ready;

            if (r_state == ST_IDLE) begin
                r_bit_idx <= '0;
            end else if ((r_state == ST_DATA) && w_tmr_done) begin
                r_shift <= {i_rx, r_shift[c_DATA_BITS-1:1]};
                if (r_bit_idx != c_LAST_BIT) begin
                    r_bit_idx <= r_bit_idx + c_BIT_IDX_W'(1);
                end
            end

            // A byte landing while the held one is being taken replaces it directly.
            if (w_deliver && (!o_valid || i_ready)) begin
                o_data  <= r_shift;
                o_valid <= 1'b1;
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

    assign o_busy = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_rx_ctrl
// Brief   : Scoreboard bench for uart_rx_ctrl at 16 clocks per bit.
// Revision: 1.0  initial release
// ============================================================================
module tb_uart_rx_ctrl;

    localparam int CPB    = 16;
    localparam int K_XFER = 0;
    localparam int K_FERR = 1;
    localparam int K_OVR  = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       rx    = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q[$];

    uart_rx_ctrl #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rx        (rx),
        .o_data      (data),
        .o_valid     (valid),
        .i_ready     (ready),
        .o_frame_err (frame_err),
        .o_overrun   (overrun),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input int n);
        repeat (n) tick();
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        hold(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            hold(CPB);
        end
        rx = stop_bit;
        hold(CPB);
    endtask

    task automatic expect_ev(input int kind, input logic [7:0] d, input int c);
        exp_t e;
        e.kind = kind;
        e.data = d;
        e.cyc  = c;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic on_event(input int kind, input logic [7:0] d);
        exp_t e;
        n_cmp++;
        if (q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: kind %0d data 0x%0h at cycle %0d, expected none",
                     kind, d, cyc);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || (kind == K_XFER && e.data !== d) ||
                (e.cyc >= 0 && e.cyc != cyc)) begin
                n_err++;
                $display("FAIL event: got kind %0d data 0x%0h cycle %0d, expected kind %0d data 0x%0h cycle %0d",
                         kind, d, cyc, e.kind, e.data, e.cyc);
            end
        end
    endtask

    // Monitor: every observable output event is matched against the queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid && ready) on_event(K_XFER, data);
            if (frame_err)      on_event(K_FERR, 8'h00);
            if (overrun)        on_event(K_OVR, 8'h00);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int n;

        // Reset state
        hold(3);
        chk("rst_valid", valid, 0);
        chk("rst_data", data, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        hold(5);

        // Single frame, consumer always ready, fixed latency
        ready = 1'b1;
        n = cyc;
        expect_ev(K_XFER, 8'hA5, n + 153);
        send_frame(8'hA5, 1'b1);
        hold(20);
        chk("a5_drained", q.size(), 0);

        // Short low glitch rejected at the mid-start sample
        n = cyc;
        rx = 1'b0;
        hold(4);
        rx = 1'b1;
        hold(4);
        chk("glitch_busy_c7", busy, 1);
        hold(1);
        chk("glitch_idle_c8", busy, 0);
        hold(30);

        // Back-to-back frames while stalled: second one overruns
        ready = 1'b0;
        n = cyc;
        expect_ev(K_OVR, 8'h00, n + CPB * 10 + 153);
        expect_ev(K_XFER, 8'h3C, -1);
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        hold(10);
        chk("ovr_valid_held", valid, 1);
        chk("ovr_data_held", data, 8'h3C);
        ready = 1'b1;
        tick();
        tick();
        chk("ovr_valid_cleared", valid, 0);
        hold(5);

        // Stop bit low, line held low as a break, then a clean frame
        n = cyc;
        expect_ev(K_FERR, 8'h00, n + 153);
        send_frame(8'h55, 1'b0);
        hold(64);
        chk("break_busy", busy, 1);
        chk("break_no_valid", valid, 0);
        rx = 1'b1;
        tick();
        chk("break_released", busy, 0);
        hold(10);
        n = cyc;
        expect_ev(K_XFER, 8'h0F, n + 153);
        send_frame(8'h0F, 1'b1);
        hold(20);

        // Reset mid-frame abandons it silently
        rx = 1'b0;
        hold(CPB);
        rx = 1'b1;
        hold(70 - CPB);
        chk("midframe_busy", busy, 1);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_data", data, 0);
        chk("mid_rst_frame_err", frame_err, 0);
        chk("mid_rst_overrun", overrun, 0);
        chk("mid_rst_busy", busy, 0);
        rst = 1'b0;
        hold(100);
        n = cyc;
        expect_ev(K_XFER, 8'h81, n + 153);
        send_frame(8'h81, 1'b1);
        hold(20);

        // New byte delivered in the same cycle the held one is accepted
        ready = 1'b0;
        send_frame(8'h12, 1'b1);
        hold(4);
        chk("same_cycle_held", data, 8'h12);
        n = cyc;
        expect_ev(K_XFER, 8'h12, n + 152);
        expect_ev(K_XFER, 8'h34, n + 153);
        fork
            send_frame(8'h34, 1'b1);
            begin
                hold(152);
                ready = 1'b1;
            end
        join
        hold(10);
        chk("same_cycle_valid_cleared", valid, 0);
        chk("same_cycle_data", data, 8'h34);

        hold(20);
        chk("scoreboard_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
